// File: rtl/env_sweeper.sv
// env_sweeper: raster location generator. Walks (x,y) across a PIXELS_X by
// PIXELS_Y frame in row-major order and presents each location, with its
// linear address, on a valid/ready handshake. Optionally loops frames forever.
// ADDR_bits must be wide enough to hold PIXELS_X*PIXELS_Y-1; the address is
// a running count and is never recomputed from x and y.
module env_sweeper #(
    parameter int X_bits     = 10,
    parameter int Y_bits     = 9,
    parameter int PIXELS_X   = 640,
    parameter int PIXELS_Y   = 480,
    parameter int ADDR_bits  = X_bits + Y_bits,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic                 halt,
    input  logic                 out_ready,
    output logic                 out_valid,
    output logic [X_bits-1:0]    out_x,
    output logic [Y_bits-1:0]    out_y,
    output logic [ADDR_bits-1:0] out_addr,
    output logic                 out_first,
    output logic                 out_last,
    output logic                 busy,
    output logic                 frame_done,
    output logic [7:0]           frame_count
);

    typedef enum logic [1:0] {IDLE, SWEEP, DONE} sweepState;

    typedef struct packed {
        logic [Y_bits-1:0]    y;
        logic [X_bits-1:0]    x;
        logic [ADDR_bits-1:0] addr;
    } sweepLoc;

    localparam logic [X_bits-1:0] X_MAX = X_bits'(PIXELS_X - 1);
    localparam logic [Y_bits-1:0] Y_MAX = Y_bits'(PIXELS_Y - 1);

    sweepState state, stateNext;
    sweepLoc   loc;
    logic [7:0] frameCnt;
    logic       xfer;
    logic       atLineEnd;
    logic       atLast;
    logic       lastXfer;

    // handshake and position decode, all from registered state
    assign xfer      = (state == SWEEP) && out_ready;
    assign atLineEnd = (loc.x == X_MAX);
    assign atLast    = atLineEnd && (loc.y == Y_MAX);
    assign lastXfer  = xfer && atLast && !halt;

    // state register
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= stateNext;
    end

    // next-state: halt beats everything, DONE lasts exactly one cycle
    always_comb begin
        stateNext = state;
        if (halt) begin
            stateNext = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) stateNext = SWEEP;
                SWEEP:   if (xfer && atLast) stateNext = DONE;
                DONE:    stateNext = CONTINUOUS ? SWEEP : IDLE;
                default: stateNext = IDLE;
            endcase
        end
    end

    // location walker; held at zero outside SWEEP so every sweep starts at (0,0)
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            loc <= '0;
        end else if (halt || state != SWEEP) begin
            loc <= '0;
        end else if (xfer) begin
            if (atLast) begin
                loc <= '0;
            end else if (atLineEnd) begin
                loc.x    <= '0;
                loc.y    <= loc.y + Y_bits'(1);
                loc.addr <= loc.addr + ADDR_bits'(1);
            end else begin
                loc.x    <= loc.x + X_bits'(1);
                loc.addr <= loc.addr + ADDR_bits'(1);
            end
        end
    end

    // completed-frame counter, bumped on the edge that enters DONE
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)         frameCnt <= 8'd0;
        else if (lastXfer) frameCnt <= frameCnt + 8'd1;
    end

    assign out_valid   = (state == SWEEP);
    assign out_x       = loc.x;
    assign out_y       = loc.y;
    assign out_addr    = loc.addr;
    assign out_first   = out_valid && (loc.x == '0) && (loc.y == '0);
    assign out_last    = out_valid && atLast;
    assign busy        = (state != IDLE);
    assign frame_done  = (state == DONE);
    assign frame_count = frameCnt;

endmodule
